rx_demux: RTL and testbench
===========================

Name: rx_demux

Overview:
- Receive-side counterpart of the sub-AFU Tx multiplexer.
- Takes the single CCI-P Rx port from the FIU and routes it to N_SUBAFUS sub-AFU Rx ports:
  - c0 read responses and c1 write responses are routed by tag bits in mdata.
  - MMIO requests are routed by address window.
- Per-sub-AFU Tx almost-full is the FIU almost-full ORed with that sub-AFU's Tx-FIFO almost-full. Both paths are registered.

Parameters:
- N_SUBAFUS, 16, number of sub-AFU Rx ports (2..16; need not be a power of two).
- MMIO_IDX_LSB, 10, lowest bit of the MMIO DWORD address used as the sub-AFU index (1024-DW / 4 KB window per sub-AFU).

Ports:
- clk  in  1  CCI-P clock.
- reset_n  in  1  asynchronous active-low reset.
- in  in  t_if_ccip_Rx  Rx from FIU.
- tx_c0_almFull  in  1 x N_SUBAFUS  per-sub-AFU c0 Tx-FIFO almost-full from the Tx mux.
- tx_c1_almFull  in  1 x N_SUBAFUS  per-sub-AFU c1 Tx-FIFO almost-full from the Tx mux.
- out  out  t_if_ccip_Rx x N_SUBAFUS  per-sub-AFU Rx.
- bad_tag_count  out  16  saturating count of dropped responses with an out-of-range tag.

Behaviour:
- Tag definitions (LOG_N = $clog2(N_SUBAFUS)):
  - Response tag = mdata[15 -: LOG_N].
  - MMIO index = hdr.address[MMIO_IDX_LSB+LOG_N-1 : MMIO_IDX_LSB].
- Reset (reset_n low, asynchronous):
  - All out[i] valid bits (c0.rspValid, c0.mmioRdValid, c0.mmioWrValid, c1.rspValid) = 0.
  - out[i].c0TxAlmFull = out[i].c1TxAlmFull = 1, so sub-AFUs are held off during reset.
  - bad_tag_count = 0.
  - Header/data registers are don't-care.
- Pipeline, fixed 2-cycle latency, no stalls, no backpressure (CCI-P Rx has none):
  - S1: register in; compute c0 target, c0 kind (rsp / mmioRd / mmioWr), c1 target and in-range flags.
  - S2: drive out[target] channel with valid = 1; every other out[j] channel valid = 0.
- c0 response (rspValid, any resp_type including UMsg):
  - Routed by response tag.
  - UMsg (resp_type eRSP_UMSG) always goes to sub-AFU 0.
  - Delivered mdata has tag bits cleared to 0; all other header bits and data pass unchanged.
- c0 MMIO read/write:
  - Routed by MMIO index.
  - Header (address, tid, length) and data pass unchanged; the sub-AFU decodes only the low bits.
  - MMIO to an out-of-range index is dropped silently and not counted.
- c1 response (write, wrfence, intr):
  - Routed by response tag; tag bits cleared as for c0.
  - Packed multi-line write responses (format = 1) are delivered as one beat to the tagged sub-AFU.
- c0 and c1 are independent. Same-cycle c0 and c1 events to the same or to different sub-AFUs are both delivered in the same output cycle.
- Out-of-range response tag (tag >= N_SUBAFUS): response dropped.
  - bad_tag_count increments by 1, or by 2 if c0 and c1 are both bad in the same cycle.
  - Saturates at 0xFFFF.
- almFull (registered over 2 stages, same latency as data):
  - out[i].c0TxAlmFull = in.c0TxAlmFull | tx_c0_almFull[i].
  - out[i].c1TxAlmFull = in.c1TxAlmFull | tx_c1_almFull[i].
- Reset asserted mid-traffic: in-flight S1/S2 contents are discarded immediately and no valid is emitted. First valid output comes no earlier than 2 cycles after the first valid input following deassertion.

Decomposition:
- Shared package (ccip_mux_pkg), reused by the Tx mux and the sub-AFU tag stamper:
  - RSP_TAG_MSB = 15.
  - Functions rsp_tag_idx(mdata, LOG_N) and clear_rsp_tag(mdata, LOG_N).
  - Enum t_rx_c0_kind {RX_NONE, RX_RSP, RX_MMIORD, RX_MMIOWR}.
- One sub-module, rx_demux_chan: 2-stage route-and-clear slice, instantiated once for c0 and once for c1. Counter and almFull pipeline live in the top.

Test Plan:
- Reset: reset_n=0 for 3 cycles, including mid-stream with c0 responses in flight -> all out valids 0, all almFull 1, bad_tag_count 0; no stray valid after release.
- N=4, c0 rspValid mdata=0x8005 at cycle t -> out[2].c0.rspValid=1 at t+2 with mdata=0x0005 and data intact; out[0,1,3] valid 0.
- N=4, same cycle: c1 rspValid mdata=0xC0FF and c0 mmioRdValid address=0x0810, tid=0x1A -> out[3].c1 mdata=0x00FF and out[2].c0.mmioRdValid with tid=0x1A, both at t+2.
- Back-to-back c0 responses with tags 0,1,2,3,0 every cycle -> each delivered once, in order, to the matching port; no loss.
- N=3, c0 tag=3 and c1 tag=3 in the same cycle -> nothing delivered, bad_tag_count 0->2. Preload to 0xFFFE, one more bad tag -> holds 0xFFFF.
- in.c0TxAlmFull=0, tx_c0_almFull[1]=1 -> out[1].c0TxAlmFull=1 and others 0 two cycles later. in.c1TxAlmFull=1 -> all out[i].c1TxAlmFull=1.

Source files
------------

// File: rtl/ccip_mux_pkg.sv
// Shared CCI-P types and response-tag helpers used by the sub-AFU Tx mux, Rx demux and tag stamper.
// Response tags occupy the top LOG_N bits of mdata.
package ccip_mux_pkg;

    localparam int unsigned RSP_TAG_MSB = 15;
    localparam int unsigned CL_DATA_W   = 512;

    typedef logic [15:0]          t_ccip_mdata;
    typedef logic [CL_DATA_W-1:0] t_ccip_clData;

    typedef enum logic [3:0] {
        eRSP_RDLINE = 4'h0,
        eRSP_UMSG   = 4'h4
    } t_ccip_c0_rsp;

    typedef enum logic [3:0] {
        eRSP_WRLINE  = 4'h0,
        eRSP_WRFENCE = 4'h4,
        eRSP_INTR    = 4'h8
    } t_ccip_c1_rsp;

    typedef struct packed {
        logic [1:0]   vc_used;
        logic         rsvd1;
        logic         hit_miss;
        logic [1:0]   rsvd0;
        logic [1:0]   cl_num;
        t_ccip_c0_rsp resp_type;
        t_ccip_mdata  mdata;
    } t_ccip_c0_RspMemHdr;

    // Overlays t_ccip_c0_RspMemHdr bit-for-bit when an MMIO request is on c0.
    typedef struct packed {
        logic [15:0] address;
        logic [1:0]  length;
        logic        rsvd;
        logic [8:0]  tid;
    } t_ccip_c0_ReqMmioHdr;

    typedef struct packed {
        logic [1:0]   vc_used;
        logic         rsvd1;
        logic         hit_miss;
        logic         format;
        logic         rsvd0;
        logic [1:0]   cl_num;
        t_ccip_c1_rsp resp_type;
        t_ccip_mdata  mdata;
    } t_ccip_c1_RspMemHdr;

    typedef struct packed {
        t_ccip_c0_RspMemHdr hdr;
        t_ccip_clData       data;
        logic               rspValid;
        logic               mmioRdValid;
        logic               mmioWrValid;
    } t_if_ccip_c0_Rx;

    typedef struct packed {
        t_ccip_c1_RspMemHdr hdr;
        logic               rspValid;
    } t_if_ccip_c1_Rx;

    typedef struct packed {
        logic           c0TxAlmFull;
        logic           c1TxAlmFull;
        t_if_ccip_c0_Rx c0;
        t_if_ccip_c1_Rx c1;
    } t_if_ccip_Rx;

    typedef enum logic [1:0] {
        RX_NONE,
        RX_RSP,
        RX_MMIORD,
        RX_MMIOWR
    } t_rx_c0_kind;

    function automatic logic [4:0] rsp_tag_idx(input t_ccip_mdata mdata, input int unsigned log_n);
        return 5'(mdata >> (RSP_TAG_MSB + 1 - log_n));
    endfunction

    function automatic t_ccip_mdata clear_rsp_tag(input t_ccip_mdata mdata, input int unsigned log_n);
        return mdata & (16'hFFFF >> log_n);
    endfunction

endpackage

// File: rtl/rx_demux_chan.sv
// Two-stage route-and-clear slice for one Rx channel: picks a target port from the response
// tag or a precomputed index, strips the tag from mdata and drives a one-hot valid vector.
module rx_demux_chan
    import ccip_mux_pkg::*;
#(
    parameter  int unsigned N_SUBAFUS = 16,
    parameter  int unsigned PAYLOAD_W = 32,
    parameter  int unsigned MDATA_LSB = 0,
    localparam int unsigned LOG_N     = $clog2(N_SUBAFUS)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 valid_i,
    input  logic                 by_tag_i,
    input  logic                 force0_i,
    input  logic [LOG_N-1:0]     idx_i,
    input  logic [PAYLOAD_W-1:0] payload_i,
    output logic [N_SUBAFUS-1:0] valid_o,
    output logic [PAYLOAD_W-1:0] payload_o,
    output logic                 bad_o
);

    logic                 valid_q;
    logic                 by_tag_q;
    logic                 force0_q;
    logic [LOG_N-1:0]     idx_q;
    logic [PAYLOAD_W-1:0] payload_q;
    logic [N_SUBAFUS-1:0] sel_q, sel_d;
    logic [PAYLOAD_W-1:0] pay2_q, pay_d;

    logic [4:0] tag;
    logic [4:0] tgt;
    logic       in_range;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            sel_q   <= '0;
        end else begin
            valid_q <= valid_i;
            sel_q   <= sel_d;
        end
    end

    always_ff @(posedge clk) begin
        by_tag_q  <= by_tag_i;
        force0_q  <= force0_i;
        idx_q     <= idx_i;
        payload_q <= payload_i;
        pay2_q    <= pay_d;
    end

    // Out-of-range targets (tag or MMIO index >= N) produce no valid at all.
    always_comb begin
        tag      = rsp_tag_idx(payload_q[MDATA_LSB +: 16], LOG_N);
        tgt      = force0_q ? 5'd0 : (by_tag_q ? tag : 5'(idx_q));
        in_range = (32'(tgt) < N_SUBAFUS);
        sel_d    = '0;
        for (int unsigned j = 0; j < N_SUBAFUS; j++) begin
            sel_d[j] = valid_q && in_range && (tgt == 5'(j));
        end
        pay_d = payload_q;
        if (by_tag_q) begin
            pay_d[MDATA_LSB +: 16] = clear_rsp_tag(payload_q[MDATA_LSB +: 16], LOG_N);
        end
        bad_o = valid_q && by_tag_q && !in_range;
    end

    assign valid_o   = sel_q;
    assign payload_o = pay2_q;

endmodule

// File: rtl/rx_demux.sv
// CCI-P Rx demultiplexer: fans the FIU Rx port out to N sub-AFU Rx ports, routing responses by
// mdata tag and MMIO by address window, with registered per-port Tx almost-full.
module rx_demux
    import ccip_mux_pkg::*;
#(
    parameter int unsigned N_SUBAFUS    = 16,
    parameter int unsigned MMIO_IDX_LSB = 10
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  t_if_ccip_Rx          in,
    input  logic [N_SUBAFUS-1:0] tx_c0_almFull,
    input  logic [N_SUBAFUS-1:0] tx_c1_almFull,
    output t_if_ccip_Rx          out [N_SUBAFUS],
    output logic [15:0]          bad_tag_count
);

    localparam int unsigned LOG_N = $clog2(N_SUBAFUS);

    typedef struct packed {
        t_rx_c0_kind        kind;
        t_ccip_c0_RspMemHdr hdr;
        t_ccip_clData       data;
    } t_c0_payload;

    localparam int unsigned C0_PAY_W = $bits(t_c0_payload);
    localparam int unsigned C1_PAY_W = $bits(t_ccip_c1_RspMemHdr);

    t_rx_c0_kind          c0_kind;
    t_ccip_c0_ReqMmioHdr  mmio_hdr;
    logic [LOG_N-1:0]     c0_mmio_idx;
    logic                 c0_umsg;
    t_c0_payload          c0_pay, c0_out;
    logic [C0_PAY_W-1:0]  c0_pay_o;
    logic [C1_PAY_W-1:0]  c1_pay_o;
    t_ccip_c1_RspMemHdr   c1_out;
    logic [N_SUBAFUS-1:0] c0_sel, c1_sel;
    logic                 c0_bad, c1_bad;

    logic                 c0_af_q, c1_af_q;
    logic [N_SUBAFUS-1:0] tx_c0_af_q, tx_c1_af_q;
    logic [N_SUBAFUS-1:0] out_c0_af_q, out_c1_af_q;
    logic [15:0]          bad_cnt_q, bad_cnt_d;
    logic [1:0]           bad_inc;
    logic [16:0]          bad_sum;

    always_comb begin
        c0_kind = RX_NONE;
        if (in.c0.rspValid)         c0_kind = RX_RSP;
        else if (in.c0.mmioRdValid) c0_kind = RX_MMIORD;
        else if (in.c0.mmioWrValid) c0_kind = RX_MMIOWR;
        mmio_hdr    = t_ccip_c0_ReqMmioHdr'(in.c0.hdr);
        c0_mmio_idx = mmio_hdr.address[MMIO_IDX_LSB +: LOG_N];
        c0_umsg     = in.c0.rspValid && (in.c0.hdr.resp_type == eRSP_UMSG);
        c0_pay.kind = c0_kind;
        c0_pay.hdr  = in.c0.hdr;
        c0_pay.data = in.c0.data;
    end

    rx_demux_chan #(
        .N_SUBAFUS (N_SUBAFUS),
        .PAYLOAD_W (C0_PAY_W),
        .MDATA_LSB (CL_DATA_W)
    ) u_chan_c0 (
        .clk       (clk),
        .reset_n   (reset_n),
        .valid_i   (c0_kind != RX_NONE),
        .by_tag_i  (c0_kind == RX_RSP),
        .force0_i  (c0_umsg),
        .idx_i     (c0_mmio_idx),
        .payload_i (c0_pay),
        .valid_o   (c0_sel),
        .payload_o (c0_pay_o),
        .bad_o     (c0_bad)
    );

    rx_demux_chan #(
        .N_SUBAFUS (N_SUBAFUS),
        .PAYLOAD_W (C1_PAY_W),
        .MDATA_LSB (0)
    ) u_chan_c1 (
        .clk       (clk),
        .reset_n   (reset_n),
        .valid_i   (in.c1.rspValid),
        .by_tag_i  (1'b1),
        .force0_i  (1'b0),
        .idx_i     ('0),
        .payload_i (in.c1.hdr),
        .valid_o   (c1_sel),
        .payload_o (c1_pay_o),
        .bad_o     (c1_bad)
    );

    always_comb begin
        bad_inc   = {1'b0, c0_bad} + {1'b0, c1_bad};
        bad_sum   = {1'b0, bad_cnt_q} + {15'b0, bad_inc};
        bad_cnt_d = bad_sum[16] ? 16'hFFFF : bad_sum[15:0];
    end

    // almFull resets high so sub-AFUs stay held off until the pipeline has real values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            c0_af_q     <= 1'b1;
            c1_af_q     <= 1'b1;
            tx_c0_af_q  <= '1;
            tx_c1_af_q  <= '1;
            out_c0_af_q <= '1;
            out_c1_af_q <= '1;
            bad_cnt_q   <= '0;
        end else begin
            c0_af_q     <= in.c0TxAlmFull;
            c1_af_q     <= in.c1TxAlmFull;
            tx_c0_af_q  <= tx_c0_almFull;
            tx_c1_af_q  <= tx_c1_almFull;
            out_c0_af_q <= {N_SUBAFUS{c0_af_q}} | tx_c0_af_q;
            out_c1_af_q <= {N_SUBAFUS{c1_af_q}} | tx_c1_af_q;
            bad_cnt_q   <= bad_cnt_d;
        end
    end

    assign c0_out        = t_c0_payload'(c0_pay_o);
    assign c1_out        = t_ccip_c1_RspMemHdr'(c1_pay_o);
    assign bad_tag_count = bad_cnt_q;

    always_comb begin
        for (int unsigned i = 0; i < N_SUBAFUS; i++) begin
            out[i]                = '0;
            out[i].c0TxAlmFull    = out_c0_af_q[i];
            out[i].c1TxAlmFull    = out_c1_af_q[i];
            out[i].c0.hdr         = c0_out.hdr;
            out[i].c0.data        = c0_out.data;
            out[i].c0.rspValid    = c0_sel[i] && (c0_out.kind == RX_RSP);
            out[i].c0.mmioRdValid = c0_sel[i] && (c0_out.kind == RX_MMIORD);
            out[i].c0.mmioWrValid = c0_sel[i] && (c0_out.kind == RX_MMIOWR);
            out[i].c1.hdr         = c1_out;
            out[i].c1.rspValid    = c1_sel[i];
        end
    end

endmodule

// File: tb/tb_rx_demux.sv
// Directed bench for rx_demux: an N=4 instance for routing/almFull/reset and an N=3 instance
// for out-of-range tags and counter saturation.
module tb_rx_demux;
    import ccip_mux_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    t_if_ccip_Rx in4, in3;
    logic [3:0]  tx0_4, tx1_4;
    logic [2:0]  tx0_3, tx1_3;
    t_if_ccip_Rx out4 [4];
    t_if_ccip_Rx out3 [3];
    logic [15:0] bad4, bad3;

    logic [3:0]  c0rsp4, c0mrd4, c1rsp4, vld4, c0af4, c1af4;
    logic [2:0]  c0rsp3, vld3;

    logic [511:0]        pat;
    t_ccip_c0_ReqMmioHdr mh;
    int                  tags [5] = '{0, 1, 2, 3, 0};
    int                  n_chk = 0;
    int                  n_bad = 0;

    always #5 clk = ~clk;

    rx_demux #(.N_SUBAFUS(4), .MMIO_IDX_LSB(10)) dut4 (
        .clk(clk), .reset_n(reset_n), .in(in4), .tx_c0_almFull(tx0_4),
        .tx_c1_almFull(tx1_4), .out(out4), .bad_tag_count(bad4)
    );

    rx_demux #(.N_SUBAFUS(3), .MMIO_IDX_LSB(10)) dut3 (
        .clk(clk), .reset_n(reset_n), .in(in3), .tx_c0_almFull(tx0_3),
        .tx_c1_almFull(tx1_3), .out(out3), .bad_tag_count(bad3)
    );

    always_comb begin
        for (int j = 0; j < 4; j++) begin
            c0rsp4[j] = out4[j].c0.rspValid;
            c0mrd4[j] = out4[j].c0.mmioRdValid;
            c1rsp4[j] = out4[j].c1.rspValid;
            vld4[j]   = out4[j].c0.rspValid | out4[j].c0.mmioRdValid |
                        out4[j].c0.mmioWrValid | out4[j].c1.rspValid;
            c0af4[j]  = out4[j].c0TxAlmFull;
            c1af4[j]  = out4[j].c1TxAlmFull;
        end
        for (int j = 0; j < 3; j++) begin
            c0rsp3[j] = out3[j].c0.rspValid;
            vld3[j]   = out3[j].c0.rspValid | out3[j].c0.mmioRdValid |
                        out3[j].c0.mmioWrValid | out3[j].c1.rspValid;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_data(input string tag, input logic [511:0] got, input logic [511:0] exp);
        for (int w = 0; w < 8; w++) check(tag, got[w*64 +: 64], exp[w*64 +: 64]);
    endtask

    task automatic idle4();
        in4.c0.rspValid    = 1'b0;
        in4.c0.mmioRdValid = 1'b0;
        in4.c0.mmioWrValid = 1'b0;
        in4.c1.rspValid    = 1'b0;
    endtask

    task automatic idle3();
        in3.c0.rspValid    = 1'b0;
        in3.c0.mmioRdValid = 1'b0;
        in3.c0.mmioWrValid = 1'b0;
        in3.c1.rspValid    = 1'b0;
    endtask

    task automatic rsp4(input logic [15:0] m);
        in4.c0.hdr           = '0;
        in4.c0.hdr.resp_type = eRSP_RDLINE;
        in4.c0.hdr.cl_num    = 2'b10;
        in4.c0.hdr.mdata     = m;
        in4.c0.data          = pat;
        in4.c0.rspValid      = 1'b1;
    endtask

    task automatic bad3_pair();
        in3.c0.hdr.mdata = 16'hC000;
        in3.c0.rspValid  = 1'b1;
        in3.c1.hdr.mdata = 16'hC001;
        in3.c1.rspValid  = 1'b1;
    endtask

    initial begin
        pat     = {8{64'h0123_4567_89AB_CDEF}} ^ 512'h5A;
        reset_n = 1'b0;
        in4     = '0;
        in3     = '0;
        tx0_4   = '0; tx1_4 = '0; tx0_3 = '0; tx1_3 = '0;

        repeat (3) begin
            @(negedge clk);
            check("rst vld4", 64'(vld4), 64'h0);
        end
        check("rst c0af", 64'(c0af4), 64'hF);
        check("rst c1af", 64'(c1af4), 64'hF);
        check("rst bad4", 64'(bad4), 64'h0);
        check("rst bad3", 64'(bad3), 64'h0);
        reset_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("post-rst vld4", 64'(vld4), 64'h0);
        end
        check("idle c0af", 64'(c0af4), 64'h0);

        // single c0 response, tag 2
        rsp4(16'h8005);
        @(negedge clk); idle4(); @(negedge clk);
        check("rsp port", 64'(c0rsp4), 64'h4);
        check("rsp mdata", 64'(out4[2].c0.hdr.mdata), 64'h0005);
        check("rsp cl_num", 64'(out4[2].c0.hdr.cl_num), 64'h2);
        check_data("rsp data", out4[2].c0.data, pat);
        @(negedge clk);
        check("rsp once", 64'(vld4), 64'h0);

        // same-cycle c1 response and c0 MMIO read
        in4.c1.hdr           = '0;
        in4.c1.hdr.resp_type = eRSP_WRLINE;
        in4.c1.hdr.mdata     = 16'hC0FF;
        in4.c1.rspValid      = 1'b1;
        mh                   = '0;
        mh.address           = 16'h0810;
        mh.tid               = 9'h01A;
        in4.c0.hdr           = t_ccip_c0_RspMemHdr'(mh);
        in4.c0.mmioRdValid   = 1'b1;
        @(negedge clk); idle4(); @(negedge clk);
        check("c1 port", 64'(c1rsp4), 64'h8);
        check("c1 mdata", 64'(out4[3].c1.hdr.mdata), 64'h00FF);
        check("mmrd port", 64'(c0mrd4), 64'h4);
        check("mmrd no rsp", 64'(c0rsp4), 64'h0);
        mh = t_ccip_c0_ReqMmioHdr'(out4[2].c0.hdr);
        check("mmrd tid", 64'(mh.tid), 64'h1A);
        check("mmrd addr", 64'(mh.address), 64'h0810);

        // UMsg ignores the tag and goes to port 0
        rsp4(16'hC000);
        in4.c0.hdr.resp_type = eRSP_UMSG;
        @(negedge clk); idle4(); @(negedge clk);
        check("umsg port", 64'(c0rsp4), 64'h1);
        check("umsg bad4", 64'(bad4), 64'h0);

        // packed multi-line write response delivered as one beat
        in4.c1.hdr        = '0;
        in4.c1.hdr.format = 1'b1;
        in4.c1.hdr.mdata  = 16'h4001;
        in4.c1.rspValid   = 1'b1;
        @(negedge clk); idle4(); @(negedge clk);
        check("pack port", 64'(c1rsp4), 64'h2);
        check("pack fmt", 64'(out4[1].c1.hdr.format), 64'h1);
        check("pack mdata", 64'(out4[1].c1.hdr.mdata), 64'h0001);
        @(negedge clk);
        check("pack once", 64'(vld4), 64'h0);

        // back-to-back responses, tags 0,1,2,3,0
        for (int i = 0; i < 7; i++) begin
            if (i >= 2) begin
                check("b2b port", 64'(c0rsp4), 64'(1 << tags[i-2]));
                check("b2b mdata", 64'(out4[tags[i-2]].c0.hdr.mdata), 64'(i - 2));
            end
            if (i < 5) rsp4(16'((tags[i] << 14) | i));
            else       idle4();
            @(negedge clk);
        end
        check("b2b drained", 64'(vld4), 64'h0);

        // almFull OR and two-cycle latency
        in4.c0TxAlmFull = 1'b0;
        tx0_4           = 4'b0010;
        in4.c1TxAlmFull = 1'b1;
        @(negedge clk);
        check("af c0 early", 64'(c0af4), 64'h0);
        check("af c1 early", 64'(c1af4), 64'h0);
        @(negedge clk);
        check("af c0", 64'(c0af4), 64'h2);
        check("af c1", 64'(c1af4), 64'hF);
        in4.c1TxAlmFull = 1'b0;
        tx0_4           = '0;

        // reset asserted with responses in flight
        rsp4(16'h4000);
        @(negedge clk);
        rsp4(16'h8000);
        @(negedge clk);
        check("inflight seen", 64'(c0rsp4), 64'h2);
        reset_n = 1'b0;
        #1;
        check("mid-rst vld", 64'(vld4), 64'h0);
        check("mid-rst af", 64'(c0af4), 64'hF);
        repeat (3) begin
            @(negedge clk);
            check("mid-rst hold", 64'(vld4), 64'h0);
        end
        reset_n = 1'b1;
        idle4();
        repeat (3) begin
            @(negedge clk);
            check("mid-rst stray", 64'(vld4), 64'h0);
        end

        // N=3: double out-of-range tag
        bad3_pair();
        @(negedge clk); idle3(); @(negedge clk);
        check("n3 drop", 64'(vld3), 64'h0);
        check("n3 bad 2", 64'(bad3), 64'h2);

        // N=3: highest in-range tag
        in3.c0.hdr.mdata = 16'h8007;
        in3.c0.rspValid  = 1'b1;
        @(negedge clk); idle3(); @(negedge clk);
        check("n3 tag2", 64'(c0rsp3), 64'h4);
        check("n3 tag2 mdata", 64'(out3[2].c0.hdr.mdata), 64'h0007);

        // N=3: MMIO to out-of-range window is dropped uncounted
        mh                 = '0;
        mh.address         = 16'h0C00;
        in3.c0.hdr         = t_ccip_c0_RspMemHdr'(mh);
        in3.c0.mmioWrValid = 1'b1;
        @(negedge clk); idle3(); @(negedge clk);
        check("n3 mmio drop", 64'(vld3), 64'h0);
        check("n3 mmio nocnt", 64'(bad3), 64'h2);

        // stream bad pairs up to 0xFFFE, then saturate
        in3.c0.hdr = '0;
        bad3_pair();
        repeat (32766) @(negedge clk);
        idle3();
        repeat (2) @(negedge clk);
        check("n3 preload", 64'(bad3), 64'hFFFE);
        in3.c0.hdr.mdata = 16'hC000;
        in3.c0.rspValid  = 1'b1;
        @(negedge clk); idle3(); @(negedge clk);
        check("n3 sat", 64'(bad3), 64'hFFFF);
        bad3_pair();
        @(negedge clk); idle3(); @(negedge clk);
        check("n3 sat hold", 64'(bad3), 64'hFFFF);
        check("n3 sat drop", 64'(vld3), 64'h0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
